dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning number of 64-bit words stored (power of two, >=2).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request handshake to rsp_valid (>=1).
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  CPU presents a data-memory request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store (STUR), 0 = load (LDUR).
REQ-008 SHALL have port req_addr  input  64  byte address from the CPU ALU result.
REQ-009 SHALL have port req_wdata  input  64  store data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  CPU consumes response.
REQ-012 SHALL have port rsp_rdata  output  64  load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  request was out of range (or misaligned, see REQ-027).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; one outstanding request max.
REQ-015 SHALL drive req_ready = 1 only in IDLE and never during a cycle with rst high.
REQ-016 SHALL capture req_we, req_addr, req_wdata and load a latency counter with LATENCY-1 on the edge where req_valid && req_ready; IDLE -> WAIT.
REQ-017 SHALL in WAIT decrement the counter each edge; on the edge where the counter is 0, perform the access and go to RESP, so rsp_valid rises exactly LATENCY edges after the accept edge.
REQ-018 SHALL, for LATENCY = 1, skip WAIT: IDLE -> RESP on the accept edge with the access performed on that edge.
REQ-019 SHALL form the word index from req_addr[3 +: log2(DEPTH)]; address in range iff req_addr >> 3 < DEPTH.
REQ-020 SHALL on an in-range store write the full 64-bit word on the access edge and return rsp_rdata = 0, rsp_err = 0.
REQ-021 SHALL on an in-range load register the stored word into rsp_rdata, rsp_err = 0.
REQ-022 SHALL on an out-of-range request perform no write, return rsp_rdata = 0, rsp_err = 1.
REQ-023 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready; on the edge with rsp_valid && rsp_ready, RESP -> IDLE and clear all three.
REQ-024 SHALL ignore req_valid outside IDLE; a load following a store to the same word returns the stored value.

Reset
REQ-025 SHALL on rst force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0 at that edge, overriding any other event.
REQ-026 SHALL on rst in WAIT abandon the in-flight request without committing its write; memory contents are not cleared by rst.

Configuration
REQ-027 SHALL with macro DMEM_ALIGN_CHECK_EN defined treat req_addr[2:0] != 0 as an error (no write, rdata 0, err 1); without it, req_addr[2:0] is ignored and the access proceeds on the containing word.

Structure
REQ-028 SHALL place the FSM state enum, WORD_W = 64 and BYTE_OFF = 3 constants in shared package dmem_pkg.
REQ-029 SHALL instantiate one sub-module dmem_array (DEPTH x 64 storage, synchronous write, synchronous read).

Verification
REQ-030 SHALL cover: reset then store 0xDEADBEEF_CAFEF00D to addr 0x10, load addr 0x10 -> rsp_rdata 0xDEADBEEF_CAFEF00D, err 0.
REQ-031 SHALL cover: LATENCY = 3, accept at edge N -> rsp_valid first high at edge N+3, req_ready low until after the rsp handshake.
REQ-032 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable; new req_valid ignored; req_ready 0.
REQ-033 SHALL cover: store to addr 8*DEPTH (0x400 for DEPTH 128) -> rsp_err 1; load word 0 unchanged.
REQ-034 SHALL cover: store to 0x20 with rst asserted in WAIT -> IDLE next cycle; later load 0x20 returns its prior contents.
REQ-035 SHALL cover: load addr 0x13 -> err 1 with DMEM_ALIGN_CHECK_EN; data of word 0x10, err 0 without it.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared word geometry and FSM state encoding for the data-memory responder
package dmem_pkg;
  localparam int WORD_W = 64;
  localparam int BYTE_OFF = 3;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 64-bit word storage with synchronous write and registered read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  // contents survive reset; a read registers the addressed word
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory slave with fixed access latency; DMEM_ALIGN_CHECK_EN flags misaligned addresses
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam bit DIRECT = LATENCY == 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic we_q, accept, access, a_we, a_err, ld_ok, err_q;
  logic [WORD_W-1:0] addr_q, wdata_q, a_addr, a_wdata, arr_rdata;
  assign req_ready = state == IDLE && !rst;
  assign accept = req_valid && req_ready;
  assign rsp_valid = state == RESP;
  assign rsp_err = err_q;
  assign rsp_rdata = ld_ok ? arr_rdata : '0;
  // with no WAIT phase the access uses the live request, otherwise the captured copy
  always_comb begin
    a_we = DIRECT ? req_we : we_q;
    a_addr = DIRECT ? req_addr : addr_q;
    a_wdata = DIRECT ? req_wdata : wdata_q;
    access = DIRECT ? accept : !rst && state == WAIT && cnt == '0;
    a_err = |a_addr[WORD_W-1:BYTE_OFF+AW];
`ifdef DMEM_ALIGN_CHECK_EN
    a_err = a_err || |a_addr[BYTE_OFF-1:0];
`endif
  end
`ifndef DMEM_ALIGN_CHECK_EN
  logic unused_off;
  assign unused_off = ^a_addr[BYTE_OFF-1:0];
`endif
  // next-state: one request in flight, response held until consumed
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = DIRECT ? RESP : WAIT;
      WAIT: if (cnt == '0) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // request capture, latency countdown and response status
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err_q <= 1'b0;
      ld_ok <= 1'b0;
    end else begin
      if (accept) begin
        we_q <= req_we;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        cnt <= CW'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (access) begin
        err_q <= a_err;
        ld_ok <= !a_we && !a_err;
      end else if (rsp_valid && rsp_ready) begin
        err_q <= 1'b0;
        ld_ok <= 1'b0;
      end
    end
  end
  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk  (clk),
    .we   (access && a_we && !a_err),
    .re   (access && !a_we && !a_err),
    .addr (a_addr[BYTE_OFF +: AW]),
    .wdata(a_wdata),
    .rdata(arr_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LATENCY 3 and LATENCY 1
module tb_dmem_responder;
  localparam int LAT = 3;
  localparam logic [63:0] D  = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] W0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] B  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] LW = 64'h0000_0000_0000_FEED;
  localparam logic [63:0] P  = 64'hA5A5_A5A5_5A5A_5A5A;
  localparam logic [63:0] Q  = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] X  = 64'h7777_8888_9999_AAAA;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic v1 = 0, we1 = 0, rr1 = 0;
  logic [63:0] a1 = '0, wd1 = '0;
  logic rdy1, rv1, re1;
  logic [63:0] rd1;
  int vectors = 0, errs = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH(128), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  dmem_responder #(.DEPTH(128), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_addr(a1), .req_wdata(wd1), .rsp_valid(rv1), .rsp_ready(rr1),
    .rsp_rdata(rd1), .rsp_err(re1)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic op(input string tag, input logic we, input logic [63:0] addr, input logic [63:0] wd,
                    input int hold, input logic [63:0] exp_rd, input logic exp_er);
    int k, busy;
    logic [63:0] rd;
    logic er;
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1;
    chk({tag, "_ready"}, req_ready, 1);
    @(posedge clk);
    #1 req_valid = 0;
    k = 0; busy = 0;
    @(negedge clk);
    while (!rsp_valid && k < 20) begin
      busy += int'(req_ready);
      @(negedge clk);
      k++;
    end
    busy += int'(req_ready);
    chk({tag, "_latency"}, 64'(k), 64'(LAT));
    chk({tag, "_busy_ready"}, 64'(busy), 0);
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_we = 1; req_wdata = ~wd;
      @(negedge clk);
      chk({tag, "_hold_valid"}, rsp_valid, 1);
      chk({tag, "_hold_rdata"}, rsp_rdata, rd);
      chk({tag, "_hold_err"}, rsp_err, er);
      chk({tag, "_hold_ready"}, req_ready, 0);
    end
    req_valid = 0; rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, er, exp_er);
    chk({tag, "_clr_valid"}, rsp_valid, 0);
    chk({tag, "_clr_rdata"}, rsp_rdata, 0);
    chk({tag, "_clr_err"}, rsp_err, 0);
    chk({tag, "_idle_ready"}, req_ready, 1);
  endtask
  task automatic op1(input string tag, input logic we, input logic [63:0] addr, input logic [63:0] wd,
                     input logic [63:0] exp_rd);
    we1 = we; a1 = addr; wd1 = wd; v1 = 1;
    chk({tag, "_ready"}, rdy1, 1);
    @(posedge clk);
    #1 v1 = 0;
    @(negedge clk);
    chk({tag, "_valid"}, rv1, 1);
    chk({tag, "_rdata"}, rd1, exp_rd);
    chk({tag, "_err"}, re1, 0);
    rr1 = 1;
    @(posedge clk);
    #1 rr1 = 0;
    @(negedge clk);
    chk({tag, "_clr_valid"}, rv1, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    op("st10", 1, 64'h10, D, 0, 0, 0);
    op("ld10", 0, 64'h10, 0, 0, D, 0);
    op("st00", 1, 64'h0, W0, 0, 0, 0);
    op("st18", 1, 64'h18, B, 0, 0, 0);
    op("ld18_hold", 0, 64'h18, 0, 5, B, 0);
    op("ld18_again", 0, 64'h18, 0, 0, B, 0);
    op("st400", 1, 64'h400, 64'hBAD, 0, 0, 1);
    op("ld400", 0, 64'h400, 0, 0, 0, 1);
    op("st_hi", 1, 64'h8000_0000_0000_0000, 64'hBAD, 0, 0, 1);
    op("ld00", 0, 64'h0, 0, 0, W0, 0);
    op("st3f8", 1, 64'h3F8, LW, 0, 0, 0);
    op("ld3f8", 0, 64'h3F8, 0, 0, LW, 0);
    op("st20", 1, 64'h20, P, 0, 0, 0);
    req_we = 1; req_addr = 64'h20; req_wdata = Q; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (3) @(negedge clk);
    chk("wait_valid", rsp_valid, 0);
    rst = 1;
    @(negedge clk);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_ready_rst", req_ready, 0);
    rst = 0;
    @(negedge clk);
    chk("abort_idle_ready", req_ready, 1);
    repeat (4) @(negedge clk);
    chk("abort_no_resp", rsp_valid, 0);
    op("ld20", 0, 64'h20, 0, 0, P, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    op("ld13", 0, 64'h13, 0, 0, 0, 1);
`else
    op("ld13", 0, 64'h13, 0, 0, D, 0);
`endif
    op1("l1_st08", 1, 64'h8, X, 0);
    op1("l1_ld08", 0, 64'h8, 0, X);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
